// File: rtl/best_move_select_pkg.sv
// Shared constants for best_move_select: default widths, mate score and the packed UCI
// field layout used to build and decode move words.
package best_move_select_pkg;

    localparam int DEFAULT_MAX_POSITIONS      = 128;
    localparam int DEFAULT_MAX_POSITIONS_LOG2 = $clog2(DEFAULT_MAX_POSITIONS);
    localparam int DEFAULT_EVAL_WIDTH         = 22;
    localparam int DEFAULT_UCI_WIDTH          = 16;
    localparam int DEFAULT_MATE_SCORE         = 2 ** (DEFAULT_EVAL_WIDTH - 2);

    localparam int UCI_FROM_COL_LSB  = 0;
    localparam int UCI_FROM_ROW_LSB  = 3;
    localparam int UCI_TO_COL_LSB    = 6;
    localparam int UCI_TO_ROW_LSB    = 9;
    localparam int UCI_PROMOTION_LSB = 12;

    function automatic logic [DEFAULT_UCI_WIDTH-1:0] pack_uci(
        input logic [3:0] promotion,
        input logic [2:0] to_row,
        input logic [2:0] to_col,
        input logic [2:0] from_row,
        input logic [2:0] from_col
    );
        logic [DEFAULT_UCI_WIDTH-1:0] uci;
        uci = '0;
        uci[UCI_FROM_COL_LSB +: 3]  = from_col;
        uci[UCI_FROM_ROW_LSB +: 3]  = from_row;
        uci[UCI_TO_COL_LSB +: 3]    = to_col;
        uci[UCI_TO_ROW_LSB +: 3]    = to_row;
        uci[UCI_PROMOTION_LSB +: 4] = promotion;
        return uci;
    endfunction

endpackage

// File: rtl/best_move_select.sv
// Walks the all_moves table, keeps the best-scoring move for the side to move, then releases
// all_moves with a single am_clear_moves pulse and reports the result with a done pulse.
module best_move_select
    import best_move_select_pkg::*;
#(
    parameter int MAX_POSITIONS_LOG2 = DEFAULT_MAX_POSITIONS_LOG2,
    parameter int EVAL_WIDTH         = DEFAULT_EVAL_WIDTH,
    parameter int UCI_WIDTH          = DEFAULT_UCI_WIDTH,
    parameter int RAM_LATENCY        = 2,
    parameter int MATE_SCORE         = 2 ** (EVAL_WIDTH - 2)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 am_moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0]        am_move_count,
    input  logic                                 initial_mate,
    input  logic                                 white_to_move_out,
    input  logic signed [EVAL_WIDTH-1:0]         eval_out,
    input  logic [UCI_WIDTH-1:0]                 uci_out,
    input  logic                                 thrice_rep_out,
    input  logic                                 fifty_move_out,
    output logic [MAX_POSITIONS_LOG2-1:0]        am_move_index,
    output logic                                 am_clear_moves,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 best_valid,
    output logic [MAX_POSITIONS_LOG2-1:0]        best_index,
    output logic signed [EVAL_WIDTH-1:0]         best_eval,
    output logic [UCI_WIDTH-1:0]                 best_uci
);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StWaitReady = 3'd1;
    localparam logic [2:0] StWait      = 3'd2;
    localparam logic [2:0] StCompare   = 3'd3;
    localparam logic [2:0] StClear     = 3'd4;
    localparam logic [2:0] StDone      = 3'd5;

    localparam logic [2:0] WaitReload = 3'(RAM_LATENCY - 1);
    localparam logic signed [EVAL_WIDTH-1:0] MateEval = EVAL_WIDTH'(MATE_SCORE);

    logic [2:0]                     state_q, state_d;
    logic [2:0]                     cnt_q, cnt_d;
    logic [MAX_POSITIONS_LOG2-1:0]  idx_q, idx_d;
    logic [MAX_POSITIONS_LOG2-1:0]  count_q, count_d;
    logic                           white_q, white_d;
    logic                           clear_q, clear_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           best_valid_q, best_valid_d;
    logic [MAX_POSITIONS_LOG2-1:0]  best_index_q, best_index_d;
    logic signed [EVAL_WIDTH-1:0]   best_eval_q, best_eval_d;
    logic [UCI_WIDTH-1:0]           best_uci_q, best_uci_d;

    logic signed [EVAL_WIDTH-1:0]   score;
    logic                           take;
    logic [MAX_POSITIONS_LOG2:0]    idx_inc;
    logic                           more;

    // Draw-by-rule moves score as dead level regardless of the static eval.
    assign score   = (thrice_rep_out | fifty_move_out) ? '0 : eval_out;
    assign take    = (idx_q == '0) ||
                     (white_q ? (score > best_eval_q) : (score < best_eval_q));
    assign idx_inc = {1'b0, idx_q} + {{MAX_POSITIONS_LOG2{1'b0}}, 1'b1};
    assign more    = idx_inc < {1'b0, count_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        count_d      = count_q;
        white_d      = white_q;
        clear_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_valid_d = best_valid_q;
        best_index_d = best_index_q;
        best_eval_d  = best_eval_q;
        best_uci_d   = best_uci_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitReady;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            StWaitReady: begin
                if (am_moves_ready) begin
                    if (am_move_count == '0) begin
                        best_valid_d = 1'b0;
                        best_index_d = '0;
                        best_uci_d   = '0;
                        if (initial_mate) begin
                            best_eval_d = white_to_move_out ? -MateEval : MateEval;
                        end else begin
                            best_eval_d = '0;
                        end
                        clear_d = 1'b1;
                        state_d = StClear;
                    end else begin
                        count_d = am_move_count;
                        white_d = white_to_move_out;
                        idx_d   = '0;
                        cnt_d   = WaitReload;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StCompare: begin
                if (take) begin
                    best_eval_d  = score;
                    best_index_d = idx_q;
                    best_uci_d   = uci_out;
                    best_valid_d = 1'b1;
                end
                if (more) begin
                    idx_d   = idx_inc[MAX_POSITIONS_LOG2-1:0];
                    cnt_d   = WaitReload;
                    state_d = StWait;
                end else begin
                    clear_d = 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                idx_d   = '0;
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            white_q      <= 1'b0;
            clear_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_valid_q <= 1'b0;
            best_index_q <= '0;
            best_eval_q  <= '0;
            best_uci_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            white_q      <= white_d;
            clear_q      <= clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_valid_q <= best_valid_d;
            best_index_q <= best_index_d;
            best_eval_q  <= best_eval_d;
            best_uci_q   <= best_uci_d;
        end
    end

    assign am_move_index  = idx_q;
    assign am_clear_moves = clear_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign best_valid     = best_valid_q;
    assign best_index     = best_index_q;
    assign best_eval      = best_eval_q;
    assign best_uci       = best_uci_q;

endmodule

// File: tb/tb_best_move_select.sv
// Scoreboard bench for best_move_select: a latency-accurate move-RAM model feeds the DUT and a
// negedge monitor checks each done pulse against hand-computed expected results.
module tb_best_move_select;
    import best_move_select_pkg::*;

    localparam int LOG2   = DEFAULT_MAX_POSITIONS_LOG2;
    localparam int EW     = DEFAULT_EVAL_WIDTH;
    localparam int UW     = DEFAULT_UCI_WIDTH;
    localparam int RAMLAT = 2;
    localparam int MATE   = DEFAULT_MATE_SCORE;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 am_moves_ready = 1'b0;
    logic [LOG2-1:0]      am_move_count = '0;
    logic                 initial_mate = 1'b0;
    logic                 white_to_move_out = 1'b0;
    logic signed [EW-1:0] eval_out;
    logic [UW-1:0]        uci_out;
    logic                 thrice_rep_out;
    logic                 fifty_move_out;
    logic [LOG2-1:0]      am_move_index;
    logic                 am_clear_moves;
    logic                 busy;
    logic                 done;
    logic                 best_valid;
    logic [LOG2-1:0]      best_index;
    logic signed [EW-1:0] best_eval;
    logic [UW-1:0]        best_uci;

    best_move_select #(
        .MAX_POSITIONS_LOG2(LOG2),
        .EVAL_WIDTH(EW),
        .UCI_WIDTH(UW),
        .RAM_LATENCY(RAMLAT),
        .MATE_SCORE(MATE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .am_moves_ready(am_moves_ready),
        .am_move_count(am_move_count),
        .initial_mate(initial_mate),
        .white_to_move_out(white_to_move_out),
        .eval_out(eval_out),
        .uci_out(uci_out),
        .thrice_rep_out(thrice_rep_out),
        .fifty_move_out(fifty_move_out),
        .am_move_index(am_move_index),
        .am_clear_moves(am_clear_moves),
        .busy(busy),
        .done(done),
        .best_valid(best_valid),
        .best_index(best_index),
        .best_eval(best_eval),
        .best_uci(best_uci)
    );

    always #5 clk = ~clk;

    // Move RAM model: outputs follow the address exactly RAMLAT cycles later.
    logic signed [EW-1:0] tb_eval  [0:(1<<LOG2)-1];
    logic [UW-1:0]        tb_uci   [0:(1<<LOG2)-1];
    logic                 tb_rep   [0:(1<<LOG2)-1];
    logic                 tb_fifty [0:(1<<LOG2)-1];
    logic [LOG2-1:0]      pipe     [RAMLAT];

    always @(posedge clk) begin
        pipe[0] <= am_move_index;
        for (int k = 1; k < RAMLAT; k++) pipe[k] <= pipe[k-1];
    end

    assign eval_out       = tb_eval[pipe[RAMLAT-1]];
    assign uci_out        = tb_uci[pipe[RAMLAT-1]];
    assign thrice_rep_out = tb_rep[pipe[RAMLAT-1]];
    assign fifty_move_out = tb_fifty[pipe[RAMLAT-1]];

    typedef struct {
        logic                 valid;
        logic [LOG2-1:0]      idx;
        logic signed [EW-1:0] eval;
        logic [UW-1:0]        uci;
        int                   lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   lat = 0;
    int   clear_cnt = 0;
    logic prev_clear = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            lat        = 0;
            clear_cnt  = 0;
            prev_clear = 1'b0;
        end else begin
            if (am_moves_ready) lat++;
            else lat = 0;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("best_valid", 64'(best_valid), 64'(e.valid));
                    check("best_index", 64'(best_index), 64'(e.idx));
                    check("best_eval", 64'(best_eval), 64'(e.eval));
                    check("best_uci", 64'(best_uci), 64'(e.uci));
                    check("done_latency", 64'(lat), 64'(e.lat));
                    check("clear_pulse", {clear_cnt[31:0], 31'd0, prev_clear}, {32'd1, 32'd1});
                end
                clear_cnt = 0;
            end
            if (am_clear_moves) clear_cnt++;
            prev_clear = am_clear_moves;
        end
    end

    task automatic load(input int n, input int e0, input int e1, input int e2, input int e3,
                        input logic [3:0] rep, input logic [3:0] fifty);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            tb_eval[i]  = EW'(e[i]);
            tb_rep[i]   = rep[i];
            tb_fifty[i] = fifty[i];
        end
        am_move_count = LOG2'(n);
    endtask

    task automatic run_case(input logic white, input logic mate, input int exp_idx,
                            input int exp_eval, input logic exp_valid, input bit extra);
        exp_t e;
        bit   got;
        e.valid = exp_valid;
        e.idx   = LOG2'(exp_idx);
        e.eval  = EW'(exp_eval);
        e.uci   = exp_valid ? tb_uci[exp_idx] : '0;
        e.lat   = int'(am_move_count) * (RAMLAT + 1) + 3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        white_to_move_out = white;
        initial_mate      = mate;
        start             = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        am_moves_ready = 1'b1;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'(1));
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                got   = 1'b1;
                break;
            end
            start = extra && (c % 3 == 0);
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        am_moves_ready = 1'b0;
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < (1 << LOG2); i++) begin
            tb_eval[i]  = EW'(777);
            tb_uci[i]   = pack_uci(4'(i % 5), 3'(i % 8), 3'((i + 3) % 8), 3'((i + 5) % 8),
                                   3'((i + 1) % 8));
            tb_rep[i]   = 1'b0;
            tb_fifty[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({am_move_index, am_clear_moves, busy, done, best_valid, best_index,
                   best_eval, best_uci}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        load(3, 5, 40, -7, 0, 4'b0000, 4'b0000);
        run_case(1'b1, 1'b0, 1, 40, 1'b1, 1'b0);
        run_case(1'b0, 1'b0, 2, -7, 1'b1, 1'b0);
        load(2, 10, 10, 0, 0, 4'b0000, 4'b0000);
        run_case(1'b1, 1'b0, 0, 10, 1'b1, 1'b0);
        load(2, -50, -20, 0, 0, 4'b0001, 4'b0000);
        run_case(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        load(2, 30, 60, 0, 0, 4'b0000, 4'b0010);
        run_case(1'b0, 1'b0, 1, 0, 1'b1, 1'b0);
        load(4, 7, -3, -3, 9, 4'b0000, 4'b0000);
        run_case(1'b0, 1'b0, 1, -3, 1'b1, 1'b0);
        load(0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        run_case(1'b1, 1'b1, 0, -MATE, 1'b0, 1'b0);
        run_case(1'b0, 1'b1, 0, MATE, 1'b0, 1'b0);
        run_case(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        load(3, 1, 2, 3, 0, 4'b0000, 4'b0000);
        run_case(1'b1, 1'b0, 2, 3, 1'b1, 1'b1);

        // Reset while waiting on the second move: everything must clear, no release pulse.
        load(3, 5, 40, -7, 0, 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        white_to_move_out = 1'b1;
        initial_mate      = 1'b0;
        start             = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        am_moves_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (am_move_index == LOG2'(1)) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_index1", 64'(hit), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("reset_midrun_outputs",
              64'({am_move_index, am_clear_moves, busy, done, best_valid, best_index,
                   best_eval, best_uci}), 64'(0));
        @(posedge clk);
        #1;
        reset          = 1'b0;
        am_moves_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("no_clear_after_reset", 64'(clear_cnt), 64'(0));
        run_case(1'b1, 1'b0, 1, 40, 1'b1, 1'b0);

        load(2, -(2 ** 21), 2 ** 21 - 1, 0, 0, 4'b0000, 4'b0000);
        run_case(1'b1, 1'b0, 1, 2 ** 21 - 1, 1'b1, 1'b0);
        run_case(1'b0, 1'b0, 0, -(2 ** 21), 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/best_move_select.md
Name: best_move_select

Overview:
- Consumes the move table produced by all_moves once am_moves_ready asserts.
- Walks am_move_index from 0 to am_move_count-1 and reads eval_out, uci_out, thrice_rep_out and fifty_move_out for each entry.
- Selects the best move for the side to move: maximum eval for white, minimum for black.
- Then pulses am_clear_moves to release all_moves for the next position. Sits between all_moves and the search/host control logic.

Parameters:
- MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), width of move index/count
- EVAL_WIDTH, 22, signed evaluation width
- UCI_WIDTH, 16, packed move {promotion[3:0], to_row, to_col, from_row, from_col}
- RAM_LATENCY, 2, cycles from am_move_index change to valid move-RAM outputs (range 1..7)
- MATE_SCORE, 2**(EVAL_WIDTH-2), magnitude reported when the root is checkmated

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to select the best move of the pending position
- am_moves_ready  in  1  all_moves table complete
- am_move_count  in  MAX_POSITIONS_LOG2  number of legal moves
- initial_mate  in  1  root position is checkmate
- white_to_move_out  in  1  side to move of the root (stable while am_moves_ready)
- eval_out  in  EVAL_WIDTH signed  eval of the addressed move
- uci_out  in  UCI_WIDTH  addressed move
- thrice_rep_out  in  1  addressed move draws by repetition
- fifty_move_out  in  1  addressed move draws by fifty-move rule
- am_move_index  out  MAX_POSITIONS_LOG2  move RAM address
- am_clear_moves  out  1  one-cycle pulse releasing all_moves
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle result-valid pulse
- best_valid  out  1  at least one legal move existed
- best_index  out  MAX_POSITIONS_LOG2  index of chosen move
- best_eval  out  EVAL_WIDTH signed  score of chosen move
- best_uci  out  UCI_WIDTH  chosen move

Behaviour:
- Reset values: all outputs are 0; state is IDLE.
- Reset asserted in any state returns to IDLE within one cycle. No am_clear_moves pulse is issued.
- Result registers hold until the next accepted start. start is ignored unless state is IDLE.
- States and transitions:
  - IDLE: start -> WAIT_READY, busy=1, am_move_index=0.
  - WAIT_READY: stays until am_moves_ready.
    - If am_move_count==0: best_valid=0, best_index=0, best_uci=0. best_eval = initial_mate ? (white_to_move_out ? -MATE_SCORE : +MATE_SCORE) : 0 (stalemate). Go to CLEAR.
    - Otherwise: latch count and side, am_move_index=0, go to WAIT with wait counter = RAM_LATENCY-1.
  - WAIT: decrement the counter; at 0 go to COMPARE. RAM outputs are valid exactly RAM_LATENCY cycles after the index register changes.
  - COMPARE:
    - score = (thrice_rep_out | fifty_move_out) ? 0 : eval_out.
    - Take the move if index==0, or (white ? score > best_eval : score < best_eval). Strict compare: on ties the lowest index wins.
    - When taken: best_eval=score, best_index=index, best_uci=uci_out, best_valid=1.
    - If index+1 < count: index++, reload the counter, go to WAIT. Compare index+1 at MAX_POSITIONS_LOG2+1 bits so there is no wrap.
    - Otherwise go to CLEAR.
  - CLEAR: am_clear_moves=1 for exactly one cycle, am_move_index=0, go to DONE.
  - DONE: done=1 for one cycle, busy=0 on exit, go to IDLE.
- Throughput: per-move cost is RAM_LATENCY+1 cycles. Total from am_moves_ready is count*(RAM_LATENCY+1)+3 cycles.
- Score arithmetic: full EVAL_WIDTH signed compare, no saturation.

Decomposition:
- vchess.vh already provides the piece constants.
- Add to the shared header: a MATE_SCORE default and UCI field offsets (from_col [2:0], from_row [5:3], to_col [8:6], to_row [11:9], promotion [15:12]).
- State encoding stays local.
- Single module, no sub-module. The comparator is a few lines inline.

Test Plan:
- White to move, 3 moves with evals {5, 40, -7}, RAM_LATENCY=2 -> best_index=1, best_eval=40, best_valid=1, done 12 cycles after am_moves_ready, one am_clear_moves pulse.
- Black to move, evals {5, 40, -7} -> best_index=2, best_eval=-7.
- Tie on white evals {10, 10}; repetition on white evals {-50, -20} with thrice_rep_out on index 0 -> ties give best_index=0; the repetition case gives best_index=0 with best_eval=0.
- am_move_count=0: initial_mate=1 with white to move -> best_valid=0, best_eval=-MATE_SCORE. Stalemate -> best_eval=0.
- start repeated while busy -> ignored, single done pulse.
- Reset asserted during WAIT with index=1 -> next cycle all outputs 0, IDLE, no clear pulse. A later start completes normally.
- Extreme values: evals {-2**21, 2**21-1} white, then black -> best_eval=2**21-1 for white and -2**21 for black, with no overflow.
